pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage LEGv8 pipeline. It drives the write-enable and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards between ID and EX, resolves taken branches in MEM, and freezes the pipeline while data memory is not ready. A timeout FSM halts the pipeline on a hung memory access, and saturating counters expose stall and flush statistics.

---
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the five-stage LEGv8 pipeline.
// Detects load-use hazards, redirects on taken branches resolved in MEM, freezes
// the pipeline on data-memory wait states and halts on a hung memory access.
module pipeline_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_isZeroBranch,
  input  logic             mem_isUnconBranch,
  input  logic             mem_alu_zero,
  input  logic             mem_memRead,
  input  logic             mem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             pc_sel_branch,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_stall_cycles;
  logic [CNT_W-1:0]    r_flush_count;

  logic w_mem_acc;
  logic w_taken;
  logic w_lu;
  logic w_frozen;
  logic w_active;
  logic w_pc_we;
  logic w_stall_inc;
  logic w_flush_inc;

  // Hazard terms; XZR as a destination never creates a dependency
  assign w_mem_acc = mem_memRead | mem_memwrite;
  assign w_taken   = mem_isUnconBranch | (mem_isZeroBranch & mem_alu_zero);
  assign w_lu      = ex_memRead & (ex_write_reg != XZR) &
                     ((id_uses_rs1 & (id_rs1 == ex_write_reg)) |
                      (id_uses_rs2 & (id_rs2 == ex_write_reg)));
  assign w_frozen  = ((r_state == S_RUN) & w_mem_acc & ~dmem_ready) |
                     ((r_state == S_MEM_WAIT) & ~dmem_ready);
  // Controller may act on taken/lu only outside reset, halt and freeze
  assign w_active  = rst_n & (r_state != S_HALT) & ~w_frozen;

  // Combinational control outputs: freeze > taken > load-use > normal
  always_comb begin
    w_pc_we       = 1'b0;
    ifid_we       = 1'b0;
    idex_we       = 1'b0;
    exmem_we      = 1'b0;
    memwb_we      = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_bubble  = 1'b0;
    pc_sel_branch = 1'b0;
    if (w_active) begin
      if (w_taken) begin
        w_pc_we       = 1'b1;
        ifid_we       = 1'b1;
        idex_we       = 1'b1;
        exmem_we      = 1'b1;
        memwb_we      = 1'b1;
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        exmem_bubble  = 1'b1;
        pc_sel_branch = 1'b1;
      end else if (w_lu) begin
        idex_we     = 1'b1;
        idex_bubble = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
      end else begin
        w_pc_we  = 1'b1;
        ifid_we  = 1'b1;
        idex_we  = 1'b1;
        exmem_we = 1'b1;
        memwb_we = 1'b1;
      end
    end
  end

  assign pc_we        = w_pc_we;
  assign mem_timeout  = rst_n & (r_state == S_HALT);
  assign w_stall_inc  = ~w_pc_we & (r_state != S_HALT);
  assign w_flush_inc  = w_active & w_taken;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

  // Memory-wait FSM with consecutive not-ready counter; HALT is left only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_mem_acc && !dmem_ready) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        S_MEM_WAIT: begin
          if (dmem_ready) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (r_wait_cnt == MAX_WAIT_V) begin
              r_state <= S_HALT;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state    <= S_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl (MAX_WAIT=4, CNT_W=4): vector table plus
// hand-built timeout, reset and saturation sequences, checked via a queue.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_write_reg;
  logic       id_uses_rs1, id_uses_rs2, ex_memRead;
  logic       mem_isZeroBranch, mem_isUnconBranch, mem_alu_zero;
  logic       mem_memRead, mem_memwrite, dmem_ready;
  logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic       ifid_flush, idex_bubble, exmem_bubble, pc_sel_branch, mem_timeout;
  logic [3:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memRead(ex_memRead), .ex_write_reg(ex_write_reg),
    .mem_isZeroBranch(mem_isZeroBranch), .mem_isUnconBranch(mem_isUnconBranch),
    .mem_alu_zero(mem_alu_zero),
    .mem_memRead(mem_memRead), .mem_memwrite(mem_memwrite),
    .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .pc_sel_branch(pc_sel_branch), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs and the outputs expected for that cycle (counters: value after the posedge)
  typedef struct {
    logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic       ex_mr; logic [4:0] ex_wr;
    logic       zb, ub, az, mr, mw, rdy;
    logic [4:0] we;  // {pc, ifid, idex, exmem, memwb}
    logic [2:0] fl;  // {ifid_flush, idex_bubble, exmem_bubble}
    logic       sel, to;
    logic [3:0] stall, flush;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t v(
    input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
    input logic ex_mr, input logic [4:0] ex_wr,
    input logic zb, input logic ub, input logic az,
    input logic mr, input logic mw, input logic rdy,
    input logic [4:0] we, input logic [2:0] fl, input logic sel, input logic to,
    input logic [3:0] stall, input logic [3:0] flush);
    vec_t r;
    r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.ex_mr = ex_mr; r.ex_wr = ex_wr;
    r.zb = zb; r.ub = ub; r.az = az; r.mr = mr; r.mw = mw; r.rdy = rdy;
    r.we = we; r.fl = fl; r.sel = sel; r.to = to; r.stall = stall; r.flush = flush;
    return r;
  endfunction

  function automatic vec_t idle(input logic [3:0] s, input logic [3:0] f);
    return v(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
             5'b11111, 3'b000, 1'b0, 1'b0, s, f);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    id_rs1 = x.rs1; id_uses_rs1 = x.u1; id_rs2 = x.rs2; id_uses_rs2 = x.u2;
    ex_memRead = x.ex_mr; ex_write_reg = x.ex_wr;
    mem_isZeroBranch = x.zb; mem_isUnconBranch = x.ub; mem_alu_zero = x.az;
    mem_memRead = x.mr; mem_memwrite = x.mw; dmem_ready = x.rdy;
  endtask

  // Called just after a posedge: drive, check controls at negedge, counters after next posedge
  task automatic run_vec(input vec_t x, input string tag);
    vec_t e;
    drive(x);
    exp_q.push_back(x);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".we"},    32'({pc_we, ifid_we, idex_we, exmem_we, memwb_we}), 32'(e.we));
    chk({tag, ".flush"}, 32'({ifid_flush, idex_bubble, exmem_bubble}), 32'(e.fl));
    chk({tag, ".sel"},   32'(pc_sel_branch), 32'(e.sel));
    chk({tag, ".to"},    32'(mem_timeout), 32'(e.to));
    @(posedge clk);
    #1;
    chk({tag, ".stall"}, 32'(stall_cycles), 32'(e.stall));
    chk({tag, ".fcnt"},  32'(flush_count), 32'(e.flush));
  endtask

  // Assert reset mid-cycle, check the reset-state outputs, release after a posedge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_we"},    32'({pc_we, ifid_we, idex_we, exmem_we, memwb_we}), 32'd0);
    chk({tag, ".rst_fl"},    32'({ifid_flush, idex_bubble, exmem_bubble, pc_sel_branch}), 32'd0);
    chk({tag, ".rst_to"},    32'(mem_timeout), 32'd0);
    chk({tag, ".rst_cnt"},   32'({stall_cycles, flush_count}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t x;
    rst_n = 1'b0;
    drive(idle(4'd0, 4'd0));
    @(posedge clk);
    #1;
    do_reset("init");

    // Main vector table (stall, flush are cumulative after each cycle)
    vecs.push_back(idle(4'd0, 4'd0));
    vecs.push_back(v(5, 1, 0, 0, 1, 5,   0, 0, 0, 0, 0, 1, 5'b00111, 3'b010, 0, 0, 1, 0)); // lu rs1
    vecs.push_back(idle(4'd1, 4'd0));                                                        // single bubble
    vecs.push_back(v(31, 1, 0, 0, 1, 31, 0, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 0, 1, 0)); // XZR
    vecs.push_back(v(3, 1, 7, 1, 1, 7,   0, 0, 0, 0, 0, 1, 5'b00111, 3'b010, 0, 0, 2, 0)); // lu rs2
    vecs.push_back(v(7, 0, 7, 0, 1, 7,   0, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 0, 2, 0)); // unused srcs
    vecs.push_back(v(7, 1, 0, 0, 0, 7,   0, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 0, 2, 0)); // not a load
    vecs.push_back(v(5, 1, 0, 0, 1, 5,   1, 0, 1, 0, 0, 1, 5'b11111, 3'b111, 1, 0, 2, 1)); // taken beats lu
    vecs.push_back(v(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 0, 2, 1)); // cbz not taken
    vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 5'b11111, 3'b111, 1, 0, 2, 2)); // uncond
    vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 5'b00000, 3'b000, 0, 0, 3, 2)); // wait 1
    vecs.push_back(v(5, 1, 0, 0, 1, 5,   0, 1, 0, 1, 0, 0, 5'b00000, 3'b000, 0, 0, 4, 2)); // wait 2, freeze wins
    vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 5'b00000, 3'b000, 0, 0, 5, 2)); // wait 3
    vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 1, 5'b11111, 3'b111, 1, 0, 5, 3)); // ready + taken
    vecs.push_back(idle(4'd5, 4'd3));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 5'b00000, 3'b000, 0, 0, 6, 3)); // store wait
    vecs.push_back(v(5, 1, 0, 0, 1, 5,   0, 0, 0, 0, 1, 1, 5'b00111, 3'b010, 0, 0, 7, 3)); // ready + lu
    vecs.push_back(idle(4'd7, 4'd3));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1, 5'b11111, 3'b000, 0, 0, 7, 3)); // ready access
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Hung access: 10 not-ready cycles, HALT after the 5th posedge
    do_reset("pre_to");
    for (int k = 1; k <= 10; k++) begin
      x = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 3'b000, 0,
            (k >= 6) ? 1'b1 : 1'b0, (k <= 5) ? 4'(k) : 4'd5, 4'd0);
      run_vec(x, $sformatf("to%0d", k));
    end
    // Ready after halt does not resume; a branch is ignored too
    run_vec(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b00000, 3'b000, 0, 1, 5, 0), "halt_hold");
    do_reset("halt_rst");
    run_vec(idle(4'd0, 4'd0), "post_halt");

    // Reset in the middle of a memory wait returns to RUN
    run_vec(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 3'b000, 0, 0, 1, 0), "mw_a");
    run_vec(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 3'b000, 0, 0, 2, 0), "mw_b");
    do_reset("mw_rst");
    run_vec(idle(4'd0, 4'd0), "post_mw");

    // Stall counter saturation over 18 consecutive load-use cycles
    for (int k = 1; k <= 18; k++) begin
      x = v(9, 1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 1, 5'b00111, 3'b010, 0, 0,
            (k < 15) ? 4'(k) : 4'd15, 4'd0);
      run_vec(x, $sformatf("sat_s%0d", k));
    end
    run_vec(idle(4'd15, 4'd0), "sat_s_hold");

    // Flush counter saturation over 17 taken branches
    for (int k = 1; k <= 17; k++) begin
      x = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b11111, 3'b111, 1, 0,
            4'd15, (k < 15) ? 4'(k) : 4'd15);
      run_vec(x, $sformatf("sat_f%0d", k));
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
